// File: rtl/flag_shadow_intr.sv
// flag_shadow_intr: C/Z flag shadow stack for interrupt entry/exit, IE bit, INTR_IN sync and pending latch.
// Define FLAG_SHADOW_NEST_EN for a DEPTH-entry nesting stack; otherwise a single shadow entry is built.

module flag_shadow_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

module flag_shadow_entry (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       wr_en,
  input  logic [1:0] wr_data,
  output logic [1:0] rd_data
);
  logic [1:0] ent_q, ent_d;

  always_comb ent_d = wr_en ? wr_data : ent_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign rd_data = ent_q;
endmodule

module flag_shadow_intr #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DW          = $clog2(DEPTH+1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          INTR_IN,
  input  logic          I_SET,
  input  logic          I_CLR,
  input  logic          C_FLAG,
  input  logic          Z_FLAG,
  input  logic          INTR_ACK,
  input  logic          RETI,
  input  logic          RETI_IE,
  output logic          INTR_REQ,
  output logic          SHAD_C,
  output logic          SHAD_Z,
  output logic          RESTORE_VLD,
  output logic          I_FLAG,
  output logic [DW-1:0] DEPTH_CNT,
  output logic          OVF_ERR,
  output logic          UNF_ERR
);
`ifdef FLAG_SHADOW_NEST_EN
  localparam int NDEPTH = DEPTH;
`else
  localparam int NDEPTH = 1;
`endif

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  logic                   sync_out;
  logic                   edge_q, edge_d;
  logic                   pending_q, pending_d;
  logic                   i_flag_q, i_flag_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  flags_t                 shad_q, shad_d;
  logic                   restore_q, restore_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   rise, full, empty, ack_ok, reti_ok;
  flags_t                 push_flags, top_flags;
  logic [NDEPTH-1:0]      ent_we;
  logic [NDEPTH-1:0][1:0] ent_rd;

  flag_shadow_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (INTR_IN),
    .q     (sync_out)
  );

  for (genvar i = 0; i < NDEPTH; i++) begin : g_ent
    assign ent_we[i] = ack_ok && (cnt_q == DW'(i));
    flag_shadow_entry u_ent (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .wr_en   (ent_we[i]),
      .wr_data (push_flags),
      .rd_data (ent_rd[i])
    );
  end

  always_comb begin
    rise       = sync_out & ~edge_q;
    full       = (cnt_q == DW'(NDEPTH));
    empty      = (cnt_q == '0);
    INTR_REQ   = pending_q & i_flag_q & ~full;
    // RETI owns the cycle: a coincident ACK is dropped and pending survives
    ack_ok     = INTR_ACK & ~RETI & INTR_REQ;
    reti_ok    = RETI & ~empty;
    push_flags = '{c: C_FLAG, z: Z_FLAG};
  end

  always_comb begin
    top_flags = '0;
    for (int i = 0; i < NDEPTH; i++)
      if (cnt_q == DW'(i + 1)) top_flags = flags_t'(ent_rd[i]);
  end

  always_comb begin
    edge_d    = sync_out;
    pending_d = rise | (pending_q & ~ack_ok);
    cnt_d     = cnt_q;
    if (ack_ok)       cnt_d = cnt_q + DW'(1);
    else if (reti_ok) cnt_d = cnt_q - DW'(1);
    i_flag_d = i_flag_q;
    if (ack_ok)       i_flag_d = 1'b0;
    else if (reti_ok) i_flag_d = RETI_IE;
    else if (I_CLR)   i_flag_d = 1'b0;
    else if (I_SET)   i_flag_d = 1'b1;
    shad_d    = reti_ok ? top_flags : shad_q;
    restore_d = reti_ok;
    ovf_d     = ovf_q | (INTR_ACK & ~RETI & ~INTR_REQ & full);
    unf_d     = unf_q | (RETI & empty);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      edge_q    <= 1'b0;
      pending_q <= 1'b0;
      i_flag_q  <= 1'b0;
      cnt_q     <= '0;
      shad_q    <= '0;
      restore_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      pending_q <= pending_d;
      i_flag_q  <= i_flag_d;
      cnt_q     <= cnt_d;
      shad_q    <= shad_d;
      restore_q <= restore_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign SHAD_C      = shad_q.c;
  assign SHAD_Z      = shad_q.z;
  assign RESTORE_VLD = restore_q;
  assign I_FLAG      = i_flag_q;
  assign DEPTH_CNT   = cnt_q;
  assign OVF_ERR     = ovf_q;
  assign UNF_ERR     = unf_q;
endmodule

// File: doc/flag_shadow_intr.md
# flag_shadow_intr

Interrupt-entry/exit companion to the C/Z flag register. It captures the live C and Z flags when the control unit accepts an interrupt. On RETID/RETIE it hands them back as a registered restore pulse that drives the flag register's load-from-shadow path. It also owns the interrupt-enable bit, synchronizes the external interrupt, and latches pending requests. It sits between the external `INTR_IN` pin, the control-unit FSM, and the flag register.

## Interface
- `DEPTH`, 4: shadow stack entries, legal range 1..8.
- `SYNC_STAGES`, 2: synchronizer flops on `INTR_IN`, minimum 2.
- `DW`, $clog2(DEPTH+1): width of `DEPTH_CNT`.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `INTR_IN`  in  1  asynchronous external interrupt request, rising-edge sensitive.
- `I_SET`  in  1  SEI: set the interrupt enable.
- `I_CLR`  in  1  CLI: clear the interrupt enable.
- `C_FLAG`  in  1  live carry from the flag register.
- `Z_FLAG`  in  1  live zero from the flag register.
- `INTR_ACK`  in  1  control unit enters the ISR this cycle.
- `RETI`  in  1  return-from-interrupt pulse.
- `RETI_IE`  in  1  sampled with `RETI`; 1 = RETIE, 0 = RETID.
- `INTR_REQ`  out  1  interrupt request to the control unit.
- `SHAD_C`  out  1  restored carry.
- `SHAD_Z`  out  1  restored zero.
- `RESTORE_VLD`  out  1  one-cycle pulse; the flag register loads `SHAD_C`/`SHAD_Z`.
- `I_FLAG`  out  1  interrupt enable.
- `DEPTH_CNT`  out  DW  occupied shadow entries.
- `OVF_ERR`  out  1  sticky overflow error: ACK while full.
- `UNF_ERR`  out  1  sticky underflow error: RETI while empty.

## Operation
- **Reset.** While `RST_N`=0: sync chain, edge register, `pending`, `I_FLAG`, stack pointer, `SHAD_C`, `SHAD_Z`, `RESTORE_VLD`, `OVF_ERR` and `UNF_ERR` are all 0. Reset mid-ISR discards all stack contents.
- **Request path.** `INTR_IN` passes through `SYNC_STAGES` flops. A 0→1 transition at the sync output sets `pending`.
  - `pending` holds until accepted. Additional edges while pending are merged.
  - `INTR_REQ` = `pending` & `I_FLAG` & (`DEPTH_CNT` < `DEPTH`). It is combinational from registers.
- **Accept.** `INTR_ACK`=1 with `INTR_REQ`=1 does the following:
  - pushes {`C_FLAG`,`Z_FLAG`} at index `DEPTH_CNT`;
  - increments `DEPTH_CNT`;
  - clears `pending`;
  - clears `I_FLAG`.
- **Accept edge cases.**
  - `INTR_ACK` with `INTR_REQ`=0 and `DEPTH_CNT`=`DEPTH`: sets `OVF_ERR`; no other effect.
  - `INTR_ACK` with `INTR_REQ`=0 otherwise: ignored.
  - An edge arriving in the same cycle as an accepted ACK re-sets `pending`. The new request wins over the clear.
- **Return.** `RETI`=1 with `DEPTH_CNT`>0 does the following:
  - pops the top entry into `SHAD_C`/`SHAD_Z`;
  - decrements `DEPTH_CNT`;
  - pulses `RESTORE_VLD` for exactly the next cycle;
  - sets `I_FLAG` <= `RETI_IE`.
- **Return while empty.** `RETI` with `DEPTH_CNT`=0 sets `UNF_ERR`. There is no pop and no `RESTORE_VLD`, and `I_FLAG` is unchanged.
- **Simultaneous `RETI` and `INTR_ACK`.** `RETI` is processed and `INTR_ACK` is ignored; `pending` is retained.
- **`I_FLAG` update priority**, highest first:
  1. accepted ACK (clear)
  2. valid `RETI` (load `RETI_IE`)
  3. `I_CLR`
  4. `I_SET`
- `SHAD_C`/`SHAD_Z` hold their last popped value between restores.
- `OVF_ERR` and `UNF_ERR` clear only on reset.

## Timing
- `INTR_IN` rising before edge k sets `pending` at edge k+`SYNC_STAGES`. `INTR_REQ` rises in the following cycle if enabled and not full.
- ACK sampled at edge n:
  - push happens at edge n;
  - `INTR_REQ` low and `DEPTH_CNT` updated from edge n.
- `RETI` sampled at edge n:
  - `SHAD_C`, `SHAD_Z` and `RESTORE_VLD`=1 are valid during cycle n..n+1;
  - `RESTORE_VLD` returns to 0 at edge n+1 unless another valid `RETI` occurred at n+1.
- Back-to-back `RETI` on consecutive cycles pops consecutive entries, with one restore pulse per cycle.
- `INTR_IN` pulses narrower than one `CLK` period are not guaranteed to be captured.

## Configuration
- `FLAG_SHADOW_NEST_EN` defined:
  - stack depth is `DEPTH`;
  - nested interrupts are allowed once the ISR executes SEI.
- Not defined:
  - a single shadow entry is built and `DEPTH` is ignored (treated as 1);
  - `INTR_REQ` is masked whenever `DEPTH_CNT`=1, regardless of `I_FLAG`;
  - `DEPTH_CNT` keeps width DW but never exceeds 1.

## Test plan
- **Reset and basic request.** Reset, `I_SET` pulse, then `INTR_IN` 0→1 → `INTR_REQ`=1 exactly 2 cycles after the sampling edge (`SYNC_STAGES`=2); all outputs 0 before it.
- **Accept then RETIE.** With C=1, Z=0, `INTR_ACK` → `DEPTH_CNT`=1, `I_FLAG`=0, `INTR_REQ`=0. Then `RETI` with `RETI_IE`=1 → next cycle `RESTORE_VLD`=1, `SHAD_C`=1, `SHAD_Z`=0, `I_FLAG`=1, `DEPTH_CNT`=0.
- **Nested entries, macro defined, `DEPTH`=4.** Three nested entries with flags {1,1}, {0,1}, {1,0}, then three `RETI` on consecutive cycles → restore pulses deliver {1,0}, {0,1}, {1,1} in order.
- **Fill to full.** Fill to `DEPTH`=4, then raise `INTR_IN` with `I_FLAG`=1 → `INTR_REQ` stays 0, `pending`=1. A forced `INTR_ACK` → `OVF_ERR`=1, `DEPTH_CNT` stays 4.
- **Underflow and priority.**
  - `RETI` at `DEPTH_CNT`=0 → `UNF_ERR`=1, no `RESTORE_VLD`, `I_FLAG` unchanged.
  - `I_SET`+`I_CLR` together → `I_FLAG`=0.
- **Macro undefined.** With `I_FLAG` re-enabled inside the ISR, a second edge → `INTR_REQ` stays 0 until `RETI`, then rises the cycle after the pop.
